// File: rtl/pc_register.sv
// Program counter register: clear / load-from-bus / increment with strobe-conflict flag.
// Optional jump-source trace buffer compiled in when PC_TRACE_EN is defined.
module pc_register #(
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CLR,
    input  logic             INR,
    input  logic             Load,
    input  logic [15:0]      bus_in,
    output logic [WIDTH-1:0] PC,
    output logic [15:0]      pc_bus,
    output logic             conflict
`ifdef PC_TRACE_EN
    ,
    input  logic [1:0]       trace_sel,
    output logic [WIDTH-1:0] trace_data,
    output logic [2:0]       trace_count
`endif
);

    logic [WIDTH-1:0] pc_reg, pc_next;
    logic             conflict_reg, conflict_next;
    logic [1:0]       strobe_sum;

    // Bus bits above WIDTH are deliberately ignored.
    logic unused_bus_bits;
    assign unused_bus_bits = ^bus_in[15:WIDTH];

    always_comb begin
        pc_next = pc_reg;
        if (CLR)
            pc_next = '0;
        else if (Load)
            pc_next = bus_in[WIDTH-1:0];
        else if (INR)
            pc_next = pc_reg + WIDTH'(1);
    end

    assign strobe_sum    = 2'(CLR) + 2'(INR) + 2'(Load);
    assign conflict_next = (strobe_sum >= 2'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg       <= '0;
            conflict_reg <= 1'b0;
        end else begin
            pc_reg       <= pc_next;
            conflict_reg <= conflict_next;
        end
    end

    assign PC       = pc_reg;
    assign pc_bus   = 16'(pc_reg);
    assign conflict = conflict_reg;

`ifdef PC_TRACE_EN
    // A record happens only when Load actually wins priority (jump source = PC before load).
    logic             record;
    logic [WIDTH-1:0] trace_reg [4];
    logic [WIDTH-1:0] trace_next [4];
    logic [2:0]       count_reg, count_next;

    assign record = Load & ~CLR;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_trace
            if (gi == 0) begin : g_head
                assign trace_next[gi] = record ? pc_reg : trace_reg[gi];
            end else begin : g_tail
                assign trace_next[gi] = record ? trace_reg[gi-1] : trace_reg[gi];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    trace_reg[gi] <= '0;
                else
                    trace_reg[gi] <= trace_next[gi];
            end
        end
    endgenerate

    assign count_next = (record && count_reg != 3'd4) ? count_reg + 3'd1 : count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_reg <= 3'd0;
        else
            count_reg <= count_next;
    end

    assign trace_count = count_reg;
    assign trace_data  = ({1'b0, trace_sel} < count_reg) ? trace_reg[trace_sel] : '0;
`endif

endmodule

// File: tb/tb_pc_register.sv
// Randomized + directed bench for pc_register against a queue-based behavioural model.
// Trace checks are included when PC_TRACE_EN is defined.
module tb_pc_register;

    localparam int WIDTH = 12;
    localparam int MASK  = (1 << WIDTH) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             CLR = 1'b0, INR = 1'b0, Load = 1'b0;
    logic [15:0]      bus_in = '0;
    logic [WIDTH-1:0] PC;
    logic [15:0]      pc_bus;
    logic             conflict;
`ifdef PC_TRACE_EN
    logic [1:0]       trace_sel = '0;
    logic [WIDTH-1:0] trace_data;
    logic [2:0]       trace_count;
`endif

    pc_register #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .CLR(CLR), .INR(INR), .Load(Load),
        .bus_in(bus_in), .PC(PC), .pc_bus(pc_bus), .conflict(conflict)
`ifdef PC_TRACE_EN
        , .trace_sel(trace_sel), .trace_data(trace_data), .trace_count(trace_count)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model state
    int unsigned m_pc = 0;
    int unsigned m_conf = 0;
    int unsigned m_trace[$];

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 0;
        m_conf = 0;
        m_trace.delete();
    endtask

    task automatic model_edge(input bit c, input bit i, input bit l, input int unsigned b);
        int unsigned old_pc;
        old_pc = m_pc;
        m_conf = ((c + i + l) >= 2) ? 1 : 0;
        if (c)      m_pc = 0;
        else if (l) m_pc = b & MASK;
        else if (i) m_pc = (m_pc + 1) % (1 << WIDTH);
        if (l && !c) begin
            m_trace.push_front(old_pc);
            if (m_trace.size() > 4) void'(m_trace.pop_back());
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, PC, m_pc);
        check({tag, ".pc_bus"}, pc_bus, m_pc);
        check({tag, ".conflict"}, conflict, m_conf);
`ifdef PC_TRACE_EN
        check({tag, ".trace_count"}, trace_count, m_trace.size());
        for (int s = 0; s < 4; s++) begin
            trace_sel = 2'(s);
            #0.1;
            check($sformatf("%s.trace%0d", tag, s), trace_data,
                  (s < m_trace.size()) ? m_trace[s] : 0);
        end
`endif
    endtask

    task automatic step(input string tag, input bit c, input bit i, input bit l, input int unsigned b);
        @(negedge clk);
        CLR = c; INR = i; Load = l; bus_in = 16'(b);
        @(posedge clk);
        model_edge(c, i, l, b);
        #1;
        $display("[TB] %s clr=%0b inr=%0b load=%0b bus=%04h -> pc=%03h conflict=%0b",
                 tag, c, i, l, b[15:0], PC, conflict);
        check_all(tag);
    endtask

    // Reset asserted mid-cycle with random strobes that must be lost.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        CLR = 1'($urandom); INR = 1'($urandom); Load = 1'($urandom); bus_in = 16'($urandom);
        rst = 1'b1;
        #1;
        model_reset();
        $display("[TB] %s async reset -> pc=%03h", tag, PC);
        check_all(tag);
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        @(negedge clk);
        rst = 1'b0; CLR = 0; INR = 0; Load = 0;
    endtask

    initial begin
        // Reset while PC holds 0x123
        step("pre", 0, 0, 1, 16'h0123);
        check("pre.pc_is_123", PC, 32'h123);
        async_reset("reset");
        check("reset.pc_const", PC, 0);

        // Increment and wrap
        step("ld_ffe", 0, 0, 1, 16'h0FFE);
        step("inr1", 0, 1, 0, 0);
        check("inr1.const", PC, 32'hFFF);
        step("inr2", 0, 1, 0, 0);
        check("inr2.wrap", PC, 0);
        step("inr3", 0, 1, 0, 0);
        check("inr3.const", PC, 1);

        // Trace: five loads from PC=0x001
        for (int k = 1; k <= 5; k++)
            step($sformatf("trace_ld%0d", k), 0, 0, 1, k * 16'h0100);
`ifdef PC_TRACE_EN
        check("trace.count_const", trace_count, 4);
        for (int s = 0; s < 4; s++) begin
            trace_sel = 2'(s);
            #0.1;
            check($sformatf("trace.src%0d_const", s), trace_data, (4 - s) * 32'h100);
        end
`endif
        step("trace_clr", 1, 0, 0, 0);

        // Load width
        step("ld_wide", 0, 0, 1, 16'hA5C3);
        check("ld_wide.pc_const", PC, 32'h5C3);
        check("ld_wide.bus_const", pc_bus, 32'h05C3);

        // Priority and conflict
        step("ld_010", 0, 0, 1, 16'h0010);
        step("all3", 1, 1, 1, 16'h0777);
        check("all3.conflict_const", conflict, 1);
        step("after_all3", 0, 0, 0, 0);
        check("after_all3.conflict_const", conflict, 0);
        step("ld_inr", 0, 1, 1, 16'h0200);
        check("ld_inr.pc_const", PC, 32'h200);
        step("inr_alone", 0, 1, 0, 0);
        check("inr_alone.conflict_const", conflict, 0);

        // Hold
        for (int k = 0; k < 10; k++)
            step($sformatf("hold%0d", k), 0, 0, 0, $urandom);

        // Randomized traffic with occasional mid-cycle resets
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 49) == 0)
                async_reset($sformatf("rnd_rst%0d", k));
            else
                step($sformatf("rnd%0d", k),
                     ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
                     ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 9) == 0) ? 32'h0FFF : $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
